// File: rtl/div_pkg.sv
// Shared types for the RV32M divide unit: operation encoding (matches the funct3 low bits
// used by the decoder) and the sequencer states.
package div_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        WB   = 2'b11
    } div_state_t;

    function automatic logic op_is_signed(div_op_t op);
        return ~op[0];
    endfunction

    function automatic logic op_is_rem(div_op_t op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration, purely combinational: shift in a dividend bit,
// trial-subtract the divisor, keep the difference when it does not underflow.
module div_step #(
    parameter int W = 32
) (
    input  logic [W:0]   rem_i,
    input  logic [W-1:0] divisor_i,
    input  logic         bit_i,
    output logic [W:0]   rem_o,
    output logic         q_o
);

    logic [W+1:0] shifted;
    logic [W:0]   diff;

    always_comb begin
        shifted = {rem_i, bit_i};
        // Low W+1 bits of the difference are exact whenever the subtraction is kept.
        diff    = shifted[W:0] - {1'b0, divisor_i};
        q_o     = (shifted >= {2'b00, divisor_i});
        rem_o   = q_o ? diff : shifted[W:0];
    end

endmodule

// File: rtl/div_unit.sv
// Iterative DIV/DIVU/REM/REMU, one quotient bit per cycle, DATA_WIDTH+2 cycles to write-back;
// requests accepted only when idle (no queueing). DIV_EARLY_OUT_EN: divide-by-zero/overflow skip CALC.
module div_unit
    import div_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int REG_BUS_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               op,
    input  logic [DATA_WIDTH-1:0]    rs1_data,
    input  logic [DATA_WIDTH-1:0]    rs2_data,
    input  logic [REG_BUS_WIDTH-1:0] rd_in,
    output logic                     busy,
    output logic                     write_enable,
    output logic [REG_BUS_WIDTH-1:0] rd,
    output logic [DATA_WIDTH-1:0]    rd_data
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    div_state_t               state_q, state_d;
    div_op_t                  op_q, op_d;
    logic [REG_BUS_WIDTH-1:0] idx_q, idx_d, rd_q, rd_d;
    logic [W-1:0]             dvd_q, dvd_d, dvs_q, dvs_d, rd_data_q, rd_data_d;
    logic [W:0]               rem_q, rem_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     s1_q, s1_d, s2_q, s2_d, div0_q, div0_d, ovf_q, ovf_d;

    div_op_t      in_op;
    logic         in_s1, in_s2, in_div0, in_ovf, accept;
    logic [W-1:0] in_abs1, in_abs2, fix_res;
    logic [W:0]   step_rem;
    logic         step_q;

    // Sign/magnitude fix-up plus the architectural results for x/0 and MIN/-1.
    function automatic logic [W-1:0] fixup(div_op_t f_op, logic [W-1:0] quot, logic [W-1:0] remv,
                                           logic s1, logic s2, logic div0, logic ovf,
                                           logic [W-1:0] dividend);
        logic [W-1:0] r;
        case (f_op)
            OP_DIV:  r = (s1 ^ s2) ? -quot : quot;
            OP_REM:  r = s1 ? -remv : remv;
            OP_DIVU: r = quot;
            default: r = remv;
        endcase
        if (div0)
            r = op_is_rem(f_op) ? dividend : '1;
        else if (ovf)
            r = op_is_rem(f_op) ? '0 : MIN_NEG;
        return r;
    endfunction

    always_comb begin
        in_op   = div_op_t'(op);
        in_s1   = op_is_signed(in_op) & rs1_data[W-1];
        in_s2   = op_is_signed(in_op) & rs2_data[W-1];
        in_abs1 = in_s1 ? -rs1_data : rs1_data;
        in_abs2 = in_s2 ? -rs2_data : rs2_data;
        in_div0 = (rs2_data == '0);
        in_ovf  = op_is_signed(in_op) && (rs1_data == MIN_NEG) && (rs2_data == '1);
        accept  = in_valid && in_ready;
    end

    div_step #(.W(W)) u_step (
        .rem_i     (rem_q),
        .divisor_i (dvs_q),
        .bit_i     (dvd_q[W-1]),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    // With a zero divisor the remainder register ends up holding |rs1|, so rs1 is rebuilt from it.
    assign fix_res = fixup(op_q, dvd_q, rem_q[W-1:0], s1_q, s2_q, div0_q, ovf_q,
                           s1_q ? -rem_q[W-1:0] : rem_q[W-1:0]);

`ifdef DIV_EARLY_OUT_EN
    logic [W-1:0] early_res;
    assign early_res = fixup(in_op, '0, '0, in_s1, in_s2, in_div0, in_ovf, rs1_data);
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) begin
`ifdef DIV_EARLY_OUT_EN
                state_d = (in_div0 || in_ovf) ? WB : CALC;
`else
                state_d = CALC;
`endif
            end
            CALC:    if (cnt_q == '0) state_d = FIX;
            FIX:     state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready     = (state_q == IDLE) && !rst;
        busy         = (state_q != IDLE);
        write_enable = (state_q == WB);
    end

    always_comb begin
        op_d      = op_q;
        idx_d     = idx_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        s1_d      = s1_q;
        s2_d      = s2_q;
        div0_d    = div0_q;
        ovf_d     = ovf_q;
        rd_d      = rd_q;
        rd_data_d = rd_data_q;
        case (state_q)
            IDLE: if (accept) begin
                op_d   = in_op;
                idx_d  = rd_in;
                dvd_d  = in_abs1;
                dvs_d  = in_abs2;
                rem_d  = '0;
                cnt_d  = CW'(W - 1);
                s1_d   = in_s1;
                s2_d   = in_s2;
                div0_d = in_div0;
                ovf_d  = in_ovf;
`ifdef DIV_EARLY_OUT_EN
                if (in_div0 || in_ovf) begin
                    rd_d      = rd_in;
                    rd_data_d = early_res;
                end
`endif
            end
            CALC: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[W-2:0], step_q};
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            end
            FIX: begin
                rd_d      = idx_q;
                rd_data_d = fix_res;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= OP_DIV;
            idx_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
            rd_q      <= '0;
            rd_data_q <= '0;
        end else begin
            op_q      <= op_d;
            idx_q     <= idx_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            div0_q    <= div0_d;
            ovf_q     <= ovf_d;
            rd_q      <= rd_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd      = rd_q;
    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: arithmetic reference model with per-cycle write checking,
// plus literal expectations for each directed vector.
module tb_div_unit;

    localparam int DW = 32;
    localparam int RW = 5;
`ifdef DIV_EARLY_OUT_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = 34;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [DW-1:0] rs1_data = '0;
    logic [DW-1:0] rs2_data = '0;
    logic [RW-1:0] rd_in = '0;
    logic          in_ready, busy, write_enable;
    logic [RW-1:0] rd;
    logic [DW-1:0] rd_data;

    always #5 clk = ~clk;

    div_unit #(.DATA_WIDTH(DW), .REG_BUS_WIDTH(RW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .op           (op),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .rd_in        (rd_in),
        .busy         (busy),
        .write_enable (write_enable),
        .rd           (rd),
        .rd_data      (rd_data)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    int          nc = 0;
    int          nwr = 0;
    logic        rst_seen = 1'b0;
    logic [31:0] q_data[$];
    logic [4:0]  q_rd[$];
    int          q_acc[$];
    int          q_lat[$];
    logic [31:0] last_data = '0;
    int          last_lat = 0;
    int          last_wr_nc = 0;
    int          last_acc_nc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic is_special(logic [1:0] o, logic [31:0] a, logic [31:0] b);
        return (b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // RISC-V semantics straight from arithmetic: SV int division truncates toward zero.
    function automatic logic [31:0] model(logic [1:0] o, logic [31:0] a, logic [31:0] b);
        int sa, sb;
        if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : 32'h8000_0000;
            sa = $signed(a);
            sb = $signed(b);
            return o[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return o[1] ? (a % b) : (a / b);
    endfunction

    function automatic int exp_lat(logic [1:0] o, logic [31:0] a, logic [31:0] b);
        return is_special(o, a, b) ? SPECIAL_LAT : DW + 2;
    endfunction

    always @(negedge clk) begin
        nc++;
        if (rst_seen) begin
            chk("rst_write_enable", write_enable, 0);
            chk("rst_rd", rd, 0);
            chk("rst_rd_data", rd_data, 0);
            chk("rst_busy", busy, 0);
        end
        if (rst) begin
            chk("rst_in_ready", in_ready, 0);
            q_data.delete(); q_rd.delete(); q_acc.delete(); q_lat.delete();
        end else begin
            chk("busy_vs_ready", busy, !in_ready);
            if (write_enable) begin
                if (q_data.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL spurious_write: rd=%0d data=0x%08h expected no write", rd, rd_data);
                end else begin
                    chk("wr_rd", rd, q_rd[0]);
                    chk("wr_data", rd_data, q_data[0]);
                    chk("wr_latency", nc - q_acc[0], q_lat[0]);
                    last_data  = rd_data;
                    last_lat   = nc - q_acc[0];
                    last_wr_nc = nc;
                    void'(q_data.pop_front()); void'(q_rd.pop_front());
                    void'(q_acc.pop_front()); void'(q_lat.pop_front());
                    nwr++;
                end
            end else if (q_data.size() != 0 && nc - q_acc[0] > q_lat[0]) begin
                n_chk++; n_fail++;
                $display("FAIL missing_write: none by cycle %0d, required by %0d", nc, q_acc[0] + q_lat[0]);
                void'(q_data.pop_front()); void'(q_rd.pop_front());
                void'(q_acc.pop_front()); void'(q_lat.pop_front());
            end
            if (in_valid && in_ready) begin
                q_data.push_back(model(op, rs1_data, rs2_data));
                q_rd.push_back(rd_in);
                q_acc.push_back(nc);
                q_lat.push_back(exp_lat(op, rs1_data, rs2_data));
                last_acc_nc = nc;
            end
        end
        rst_seen = rst;
    end

    // Returns just after the accept edge with in_valid still asserted.
    task automatic start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r);
        bit ok = 0;
        @(posedge clk); #1;
        op = o; rs1_data = a; rs2_data = b; rd_in = r; in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1");
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (q_data.size() == 0 && in_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL idle_timeout: pending writes got %0d expected 0", q_data.size());
        end
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r, input logic [31:0] lit, input string name);
        start(o, a, b, r);
        in_valid = 1'b0;
        wait_idle();
        chk(name, last_data, lit);
    endtask

    initial begin
        int w0, wr1_nc;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        run(2'b01, 100, 7, 5, 14, "divu_100_7");
        chk("divu_latency", last_lat, 34);
        chk("divu_rd_hold", rd, 5);
        run(2'b11, 100, 7, 5, 2, "remu_100_7");
        run(2'b00, 32'hFFFF_FF9C, 7, 3, 32'hFFFF_FFF2, "div_m100_7");
        run(2'b10, 32'hFFFF_FF9C, 7, 3, 32'hFFFF_FFFE, "rem_m100_7");
        run(2'b00, 100, 32'hFFFF_FFF9, 4, 32'hFFFF_FFF2, "div_100_m7");
        run(2'b10, 100, 32'hFFFF_FFF9, 4, 2, "rem_100_m7");
        run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 6, 32'h8000_0000, "div_overflow");
        chk("overflow_latency", last_lat, SPECIAL_LAT);
        run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 6, 0, "rem_overflow");
        run(2'b01, 1234, 0, 7, 32'hFFFF_FFFF, "divu_by_zero");
        chk("div0_latency", last_lat, SPECIAL_LAT);
        run(2'b11, 1234, 0, 7, 1234, "remu_by_zero");
        run(2'b00, 32'hFFFF_FFFB, 0, 8, 32'hFFFF_FFFF, "div_m5_by_zero");
        run(2'b10, 32'hFFFF_FFFB, 0, 8, 32'hFFFF_FFFB, "rem_m5_by_zero");
        run(2'b01, 32'hFFFF_FFFF, 1, 9, 32'hFFFF_FFFF, "divu_max_1");
        run(2'b00, 0, 5, 0, 0, "div_zero_rd0");

        // Second request held on in_valid while the first is in flight.
        w0 = nwr;
        start(2'b01, 1000, 10, 10);
        op = 2'b11; rs1_data = 1000; rs2_data = 7; rd_in = 11;
        repeat (5) begin
            @(negedge clk);
            chk("held_in_ready", in_ready, 0);
            chk("held_busy", busy, 1);
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (nwr >= w0 + 1) break;
        end
        chk("held_first_result", last_data, 100);
        wr1_nc = last_wr_nc;
        repeat (3) @(posedge clk);
        #1 in_valid = 1'b0;
        wait_idle();
        chk("held_second_result", last_data, 6);
        chk("held_accept_after_wb", last_acc_nc - wr1_nc, 1);
        chk("held_write_count", nwr - w0, 2);

        // Reset during the 10th CALC cycle abandons the operation.
        start(2'b01, 1000, 3, 12);
        in_valid = 1'b0;
        w0 = nwr;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (50) @(negedge clk);
        chk("no_write_after_rst", nwr, w0);
        chk("rst_rd_cleared", rd, 0);
        chk("rst_data_cleared", rd_data, 0);
        run(2'b01, 9, 3, 13, 3, "divu_9_3_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative RV32M divide/remainder unit sitting between the regfile read ports and its write port. Accepts rs1/rs2 operand data plus a destination index through a valid/ready handshake, runs a restoring division one bit per cycle, then drives a single-cycle write into the regfile write port. Handles DIV, DIVU, REM and REMU, including the RISC-V divide-by-zero and signed-overflow results.

## Interface
- DATA_WIDTH, 32, operand/result width
- REG_BUS_WIDTH, $clog2(DATA_WIDTH), register index width
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  unit idle and can accept a request
- op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- rs1_data  in  DATA_WIDTH  dividend
- rs2_data  in  DATA_WIDTH  divisor
- rd_in  in  REG_BUS_WIDTH  destination register index
- busy  out  1  operation in flight; the hazard logic stalls on it
- write_enable  out  1  regfile write strobe, one cycle per operation
- rd  out  REG_BUS_WIDTH  regfile write index
- rd_data  out  DATA_WIDTH  regfile write data

## Operation
- States: IDLE, CALC, FIX, WB.
- IDLE: in_ready=1. A rising edge with in_valid&&in_ready captures op, rd_in, |rs1|, |rs2| and both sign bits, loads the counter with DATA_WIDTH-1, and moves to CALC.
- Signed ops (DIV/REM) use absolute values as unsigned. |0x80000000| = 0x80000000.
- CALC: one restoring step per edge. The partial remainder is DATA_WIDTH+1 bits: shift in the next dividend bit, trial-subtract the divisor, keep the result if it is non-negative, and shift the quotient bit in. After DATA_WIDTH steps (counter hits 0), move to FIX.
- FIX: computes the final rd_data.
  - DIV: quotient, negated if the signs differ.
  - REM: remainder, negated if the dividend is negative.
  - Unsigned ops: raw quotient or remainder.
  - Special-case overrides always apply:
    - divisor 0: quotient all ones, remainder = original rs1_data.
    - signed op with rs1=0x80000000 and rs2=0xFFFFFFFF: quotient 0x80000000, remainder 0.
  - FIX then moves to WB.
- WB: write_enable=1, rd=captured rd_in, rd_data valid. Next edge returns to IDLE and clears write_enable.
- rd_in=0: the write is still issued and the regfile discards it.
- No backpressure on the write side; the regfile always accepts.
- busy = (state != IDLE).
- in_ready = (state == IDLE). Requests presented while not ready are ignored and not queued.

## Timing
- Reset edge: state IDLE, write_enable=0, rd=0, rd_data=0, busy=0, counter=0. in_ready is 0 while rst=1 and 1 from the first cycle after.
- Reset mid-operation (any state) abandons the operation with no write.
- Latency, normal path: accept edge at E0, write_enable high during the cycle after edge E0+DATA_WIDTH+1 (34 cycles for DATA_WIDTH=32). in_ready rises the cycle after WB.
- Back-to-back throughput: one operation per DATA_WIDTH+3 cycles.
- Operand inputs only need to be valid on the accept edge.
- rd and rd_data hold their last value after WB until the next WB.

## Configuration
- DIV_EARLY_OUT_EN defined: on the accept edge, divisor 0 and signed overflow go directly to WB with the final result registered. write_enable is high in the cycle after the accept edge.
- DIV_EARLY_OUT_EN undefined: these cases take the full CALC/FIX path; results are identical and only latency differs.

## Structure
- Shared core package: div_op_t enum (DIV, DIVU, REM, REMU) and div_state_t enum. The decoder reuses the op encoding.
- Sub-module div_step: combinational single restoring iteration (partial remainder, divisor, next dividend bit in; new remainder and quotient bit out), instantiated once in div_unit.

## Test plan
- DIVU 100/7, rd_in=5 -> write_enable exactly 34 cycles after accept, rd=5, rd_data=14; REMU same operands -> 2.
- DIV 0xFFFFFF9C(-100)/7 -> 0xFFFFFFF2; REM -> 0xFFFFFFFE; DIV 100/0xFFFFFFF9 -> 0xFFFFFFF2, REM -> 2.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0. Write occurs 1 cycle after accept with DIV_EARLY_OUT_EN, 34 cycles without.
- DIVU 1234/0 -> 0xFFFFFFFF, REMU -> 1234; DIV 0xFFFFFFFB/0 -> 0xFFFFFFFF, REM -> 0xFFFFFFFB.
- Second request held on in_valid during CALC -> in_ready=0, busy=1, exactly one write carrying the first result; the second is accepted the cycle after WB.
- rst pulsed at the 10th CALC cycle -> no write_enable, outputs return to reset values; a following DIVU 9/3 -> 3.
